irq_arbiter: RTL and testbench

Machine-level external interrupt controller placed between peripheral interrupt lines and the core's `int_flag_i` input. It synchronises up to NUM_SRC raw interrupt lines, latches them as pending, and selects the highest-priority enabled source (lowest index wins). It drives that source's ID on `int_flag_o` and runs a claim/complete handshake over the peripheral bus, so that only one external interrupt is in service at a time.

---
 rtl/irq_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_irq_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module : irq_arbiter
// Desc   : Fixed-priority external interrupt controller with claim/complete
//          handshake; only one interrupt is in service at a time.
// Rev    : 1.0  initial release
// ============================================================================
module irq_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int INT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    output logic [INT_W-1:0]   int_flag_o
);

    localparam logic [2:0] OFF_PENDING  = 3'd0;
    localparam logic [2:0] OFF_ENABLE   = 3'd1;
    localparam logic [2:0] OFF_MODE     = 3'd2;
    localparam logic [2:0] OFF_CLAIM    = 3'd3;
    localparam logic [2:0] OFF_COMPLETE = 3'd4;
    localparam logic [2:0] OFF_STATUS   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_REQ     = 3'b010,
        ST_SERVICE = 3'b100
    } state_t;

    logic [NUM_SRC-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    state_t             state_q, state_d;
    logic [4:0]         latched_id_q, latched_id_d;
    logic [4:0]         active_id_q, active_id_d;
    logic               in_service_q, in_service_d;
    logic [INT_W-1:0]   int_flag_q, int_flag_d;

    logic               wr, rd;
    logic [2:0]         off;
    logic [NUM_SRC-1:0] edge_ev, clr;
    logic [4:0]         cand_id;
    logic               cand_valid;
    logic               claim_rd, complete_wr;
    logic               unused_bits;

    assign unused_bits = ^{addr_i, data_i};

    // Descending scan so the lowest enabled pending index is the last to win.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i] && enable_q[i]) begin
                cand_valid = 1'b1;
                cand_id    = 5'(i);
            end
        end
    end

    always_comb begin
        s1_d = irq_i;
        s2_d = s1_q;
        s3_d = s2_q;

        wr  = req_i & we_i;
        rd  = req_i & ~we_i;
        off = addr_i[4:2];

        edge_ev     = s2_q & ~s3_q;
        claim_rd    = rd && (off == OFF_CLAIM) && (state_q == ST_REQ);
        complete_wr = wr && (off == OFF_COMPLETE) && (state_q == ST_SERVICE)
                      && (data_i[4:0] == active_id_q);

        clr = '0;
        if (wr && (off == OFF_PENDING)) begin
            clr = data_i[NUM_SRC-1:0];
        end
        if (claim_rd) begin
            clr = clr | (NUM_SRC'(1) << latched_id_q);
        end

        // Level sources mirror the synchroniser; edge sources let a new event beat a clear.
        pending_d = (mode_q & s2_q) | (~mode_q & (edge_ev | (pending_q & ~clr)));
        enable_d  = (wr && (off == OFF_ENABLE)) ? data_i[NUM_SRC-1:0] : enable_q;
        mode_d    = (wr && (off == OFF_MODE))   ? data_i[NUM_SRC-1:0] : mode_q;

        state_d      = state_q;
        latched_id_d = latched_id_q;
        active_id_d  = active_id_q;
        in_service_d = in_service_q;
        int_flag_d   = int_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (cand_valid) begin
                    state_d      = ST_REQ;
                    latched_id_d = cand_id;
                    int_flag_d   = INT_W'(cand_id + 5'd1);
                end
            end
            ST_REQ: begin
                if (claim_rd) begin
                    state_d      = ST_SERVICE;
                    active_id_d  = latched_id_q + 5'd1;
                    in_service_d = 1'b1;
                    int_flag_d   = '0;
                end else if (!cand_valid) begin
                    state_d    = ST_IDLE;
                    int_flag_d = '0;
                end else begin
                    latched_id_d = cand_id;
                    int_flag_d   = INT_W'(cand_id + 5'd1);
                end
            end
            ST_SERVICE: begin
                if (complete_wr) begin
                    state_d      = ST_IDLE;
                    active_id_d  = '0;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                int_flag_d = '0;
            end
        endcase
    end

    always_comb begin
        data_o = '0;
        case (addr_i[4:2])
            OFF_PENDING: data_o = 32'(pending_q);
            OFF_ENABLE:  data_o = 32'(enable_q);
            OFF_MODE:    data_o = 32'(mode_q);
            OFF_CLAIM: begin
                if (state_q == ST_REQ) begin
                    data_o = 32'(latched_id_q + 5'd1);
                end else if (state_q == ST_SERVICE) begin
                    data_o = 32'(active_id_q);
                end
            end
            OFF_STATUS:  data_o = {26'b0, in_service_q, active_id_q};
            default:     data_o = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            state_q      <= ST_IDLE;
            latched_id_q <= '0;
            active_id_q  <= '0;
            in_service_q <= 1'b0;
            int_flag_q   <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            state_q      <= state_d;
            latched_id_q <= latched_id_d;
            active_id_q  <= active_id_d;
            in_service_q <= in_service_d;
            int_flag_q   <= int_flag_d;
        end
    end

    assign int_flag_o = int_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// Bench for irq_arbiter: directed handshake scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_irq_arbiter;

    localparam int NUM_SRC = 8;
    localparam int INT_W   = 8;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_REQ  = 2'd1;
    localparam logic [1:0] PH_SVC  = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq;
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  flag;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    irq_arbiter #(.NUM_SRC(NUM_SRC), .INT_W(INT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_i      (irq),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .data_i     (wdata),
        .data_o     (rdata),
        .int_flag_o (flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sync1;
        logic [7:0] sync2;
        logic [7:0] hist;
        logic [7:0] pending;
        logic [7:0] enable;
        logic [7:0] mode;
        logic [1:0] phase;
        logic [4:0] pick;
        logic [4:0] act;
        logic       busy;
    } model_t;

    model_t m;

    function automatic int lowest(logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic model_t step(model_t cur, logic [7:0] irq_v, logic rq, logic w,
                                    logic [31:0] a, logic [31:0] d);
        model_t     n;
        logic [7:0] clear;
        logic [2:0] o;
        int         c;
        n     = cur;
        clear = '0;
        o     = a[4:2];
        c     = lowest(cur.pending & cur.enable);
        n.sync1 = irq_v;
        n.sync2 = cur.sync1;
        n.hist  = cur.sync2;
        case (cur.phase)
            PH_IDLE: if (c >= 0) begin
                n.phase = PH_REQ;
                n.pick  = 5'(c);
            end
            PH_REQ: begin
                if (rq && !w && o == 3'd3) begin
                    n.phase = PH_SVC;
                    n.act   = cur.pick + 5'd1;
                    n.busy  = 1'b1;
                    clear[cur.pick[2:0]] = 1'b1;
                end else if (c < 0) begin
                    n.phase = PH_IDLE;
                end else begin
                    n.pick = 5'(c);
                end
            end
            default: if (rq && w && o == 3'd4 && d[4:0] == cur.act) begin
                n.phase = PH_IDLE;
                n.act   = '0;
                n.busy  = 1'b0;
            end
        endcase
        if (rq && w && o == 3'd0) clear = clear | d[7:0];
        for (int i = 0; i < 8; i++) begin
            if (cur.mode[i]) n.pending[i] = cur.sync2[i];
            else n.pending[i] = (cur.sync2[i] && !cur.hist[i]) || (cur.pending[i] && !clear[i]);
        end
        if (rq && w && o == 3'd1) n.enable = d[7:0];
        if (rq && w && o == 3'd2) n.mode   = d[7:0];
        return n;
    endfunction

    function automatic logic [31:0] exp_flag(model_t s);
        return (s.phase == PH_REQ) ? 32'(s.pick) + 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_data(model_t s, logic [31:0] a);
        case (a[4:2])
            3'd0: return {24'b0, s.pending};
            3'd1: return {24'b0, s.enable};
            3'd2: return {24'b0, s.mode};
            3'd3: return (s.phase == PH_REQ) ? 32'(s.pick) + 32'd1 :
                         (s.phase == PH_SVC) ? 32'(s.act) : 32'd0;
            3'd5: return {26'b0, s.busy, s.act};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, irq, req, we, addr, wdata);
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_int_flag", 32'(flag), exp_flag(m));
            check("model_data_o", rdata, exp_data(m, addr));
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr_reg(logic [2:0] o, logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = {27'b0, o, 2'b00}; wdata = d;
        tick(1);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd_reg(logic [2:0] o, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = {27'b0, o, 2'b00};
        #1 d = rdata;
        tick(1);
        req = 1'b0;
    endtask

    task automatic pulse(logic [7:0] v);
        irq = v;
        tick(1);
        irq = '0;
    endtask

    logic [31:0] r;
    logic [2:0]  off;

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; irq = '0;
        tick(2);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        check("reset_flag", 32'(flag), 32'd0);
        rd_reg(3'd5, r); check("reset_status", r, 32'd0);
        rd_reg(3'd1, r); check("reset_enable", r, 32'd0);

        // Basic handshake
        wr_reg(3'd1, 32'h01);
        pulse(8'h01);
        tick(2);  check("basic_flag_early", 32'(flag), 32'd0);
        tick(1);  check("basic_flag", 32'(flag), 32'd1);
        rd_reg(3'd3, r); check("basic_claim", r, 32'd1);
        check("basic_flag_after_claim", 32'(flag), 32'd0);
        rd_reg(3'd5, r); check("basic_status_svc", r, 32'h21);
        wr_reg(3'd4, 32'd1);
        rd_reg(3'd5, r); check("basic_status_done", r, 32'd0);

        // Priority
        wr_reg(3'd1, 32'hFF);
        pulse(8'h24);
        tick(3);  check("prio_flag", 32'(flag), 32'd3);
        rd_reg(3'd3, r); check("prio_claim", r, 32'd3);
        wr_reg(3'd4, 32'd3);
        check("prio_flag_idle", 32'(flag), 32'd0);
        tick(1);  check("prio_flag_next", 32'(flag), 32'd6);
        rd_reg(3'd3, r); check("prio_claim_next", r, 32'd6);
        wr_reg(3'd4, 32'd6);

        // Pre-emption in REQ
        pulse(8'h10);
        tick(3);  check("preempt_flag_low", 32'(flag), 32'd5);
        pulse(8'h02);
        tick(2);  check("preempt_flag_hold", 32'(flag), 32'd5);
        tick(1);  check("preempt_flag_high", 32'(flag), 32'd2);
        rd_reg(3'd3, r); check("preempt_claim", r, 32'd2);
        wr_reg(3'd4, 32'd2);
        tick(1);  check("preempt_flag_resume", 32'(flag), 32'd5);
        rd_reg(3'd3, r); check("preempt_claim_resume", r, 32'd5);
        wr_reg(3'd4, 32'd5);

        // Masking and write-1-to-clear
        wr_reg(3'd1, 32'h00);
        pulse(8'h08);
        tick(4);
        rd_reg(3'd0, r); check("mask_pending", r, 32'h08);
        check("mask_flag", 32'(flag), 32'd0);
        wr_reg(3'd0, 32'h08);
        rd_reg(3'd0, r); check("w1c_pending", r, 32'd0);

        // Level mode, wrong completion, re-request
        wr_reg(3'd2, 32'h01);
        wr_reg(3'd1, 32'h01);
        irq = 8'h01;
        tick(4);  check("level_flag", 32'(flag), 32'd1);
        rd_reg(3'd3, r); check("level_claim", r, 32'd1);
        rd_reg(3'd0, r); check("level_pending_kept", r, 32'h01);
        wr_reg(3'd4, 32'd7);
        rd_reg(3'd5, r); check("level_wrong_complete", r, 32'h21);
        wr_reg(3'd4, 32'd1);
        tick(1);  check("level_rerequest", 32'(flag), 32'd1);
        rd_reg(3'd3, r); check("level_claim2", r, 32'd1);

        // Reset mid-service
        rst_n = 1'b0;
        #1 check("rst_flag", 32'(flag), 32'd0);
        addr = {27'b0, 3'd5, 2'b00};
        #1 check("rst_status", rdata, 32'd0);
        addr = {27'b0, 3'd0, 2'b00};
        #1 check("rst_pending", rdata, 32'd0);
        irq = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) irq = irq ^ 8'(1 << $urandom_range(0, 7));
            req   = ($urandom_range(0, 2) == 0);
            we    = 1'($urandom_range(0, 1));
            off   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                off = 3'd3;
                we  = 1'b0;
            end
            addr  = $urandom;
            addr[4:2] = off;
            wdata = $urandom;
            if (off == 3'd4 && $urandom_range(0, 1) == 1) wdata[4:0] = m.act;
            if (off == 3'd0 && $urandom_range(0, 1) == 1) wdata = '0;
            tick(1);
        end
        req = 1'b0; we = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
